// File: rtl/add_arbiter.sv
// Two-requester round-robin arbiter in front of one shared N-bit adder, with a
// single-entry result register (EMPTY/FULL) and a consumed-result counter.
module add_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic [15:0]  op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic         id_q, id_d;
  logic         last_q, last_d;
  logic [15:0]  cnt_q, cnt_d;

  logic         can_issue, gnt0, gnt1, xfer, consume;
  logic [N-1:0] op_a, op_b;
  logic [N:0]   add_res;

  // last_q names the previous winner; on contention the other side wins.
  always_comb begin
    can_issue = !rst && ((state_q == EMPTY) || rsp_ready);
    gnt0      = can_issue && req0_valid && (!req1_valid || last_q);
    gnt1      = can_issue && req1_valid && (!req0_valid || !last_q);
  end

  assign xfer    = gnt0 || gnt1;
  assign consume = (state_q == FULL) && rsp_ready;
  assign op_a    = gnt1 ? req1_a : req0_a;
  assign op_b    = gnt1 ? req1_b : req0_b;
  assign add_res = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = consume ? cnt_q + 16'd1 : cnt_q;
    if (xfer) begin
      state_d = FULL;
      sum_d   = add_res[N-1:0];
      cout_d  = add_res[N];
      id_d    = gnt1;
      last_d  = gnt1;
    end else if (consume) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == FULL);
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign rsp_id     = id_q;
  assign op_count   = cnt_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, the operand and sum width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit, requester 0 presents an operand pair.
REQ-005 The block SHALL have port req0_ready, output, 1 bit, requester 0 pair accepted this cycle.
REQ-006 The block SHALL have ports req0_a and req0_b, input, N bits each, requester 0 operands.
REQ-007 The block SHALL have ports req1_valid (in, 1), req1_ready (out, 1), req1_a (in, N) and req1_b (in, N), same meaning for requester 1.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit, result register holds an unconsumed result.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit, consumer accepts the result this cycle.
REQ-010 The block SHALL have port rsp_sum, output, N bits, the result sum.
REQ-011 The block SHALL have port rsp_cout, output, 1 bit, carry out of the N-bit add.
REQ-012 The block SHALL have port rsp_id, output, 1 bit, index of the requester that produced the result.
REQ-013 The block SHALL have port op_count, output, 16 bits, number of results consumed.

Function
REQ-014 The block SHALL share one N-bit adder between the two requesters; a transfer occurs when reqX_valid and reqX_ready are both 1.
REQ-015 The block SHALL use a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 The block SHALL set can_issue = (state==EMPTY) or (state==FULL and rsp_ready).
REQ-017 The block SHALL compute reqX_ready combinationally, assert it for at most one requester per cycle, and assert it only when can_issue=1 and reqX_valid=1.
REQ-018 When only one requester is valid and can_issue=1, that requester SHALL be granted.
REQ-019 When both requesters are valid, the requester not recorded in last_grant SHALL be granted; last_grant SHALL update to the granted index on every transfer.
REQ-020 On a transfer, at the next edge, the block SHALL set rsp_sum=(a+b) mod 2^N, rsp_cout=bit N of the (N+1)-bit sum, rsp_id=granted index, and state=FULL; latency is 1 cycle and throughput is 1 result per cycle.
REQ-021 In FULL with rsp_ready=0, rsp_sum, rsp_cout and rsp_id SHALL hold stable and both reqX_ready SHALL be 0.
REQ-022 In FULL with rsp_ready=1 and no transfer, the FSM SHALL go to EMPTY.
REQ-023 In FULL with rsp_ready=1 and a transfer in the same cycle, the FSM SHALL stay FULL with the new result loaded.
REQ-024 op_count SHALL increment by 1 on each cycle with rsp_valid and rsp_ready both 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-025 rsp_ready while in EMPTY SHALL have no effect.
REQ-026 Operand values on a non-granted requester SHALL not affect any state.

Reset
REQ-027 Asserting rst SHALL immediately, independent of clk, force state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, op_count=0, and last_grant=1, so that requester 0 wins the first contention.
REQ-028 Assertion of rst mid-operation SHALL discard any held result without incrementing op_count.
REQ-029 Both reqX_ready outputs SHALL be 0 while rst=1.

Verification
REQ-030 The bench SHALL cover the single request case: req0 a=0xFFFFFFFF, b=0xFFFFFFFF, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0xFFFFFFFE, rsp_cout=1, rsp_id=0, and op_count=1 one cycle later.
REQ-031 The bench SHALL cover contention: both valid for 4 cycles with rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows 0,1,0,1 one cycle later.
REQ-032 The bench SHALL cover backpressure: result 0x00000003 (1+2) held with rsp_ready=0 for 3 cycles -> sum stable, both ready=0; rsp_ready=1 -> pending req1 (5+6) is granted in the same cycle and rsp_sum=0x0000000B next cycle.
REQ-033 The bench SHALL cover drain: FULL, rsp_ready=1, no request -> EMPTY next cycle, rsp_valid=0.
REQ-034 The bench SHALL cover reset mid-operation: rst pulsed while FULL -> rsp_valid=0 and op_count=0 before the next clk edge; the first contention afterwards grants req0.
REQ-035 The bench SHALL cover counter wrap: 65536 consumed results -> op_count=0x0000.
